// File: rtl/inst_dispatch_queue_if.sv
// Host-to-control-unit dispatch bus: host push side, issue side and status.
interface inst_dispatch_queue_if #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic [31:0]      host_wdata;
  logic             host_write;
  logic             flush;
  logic             host_full;
  logic             host_overflow;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      inst_out;
  logic             inst_write;
  logic             isrunning;
  logic             units_busy;
  logic             drained;

  modport master (
    output host_wdata, host_write, flush, isrunning, units_busy,
    input  host_full, host_overflow, fifo_count, inst_out, inst_write, drained
  );

  modport slave (
    input  host_wdata, host_write, flush, isrunning, units_busy,
    output host_full, host_overflow, fifo_count, inst_out, inst_write, drained
  );
endinterface

// File: rtl/inst_dispatch_queue.sv
// Instruction FIFO between the host IO path and the control unit. Issues one
// word at a time once the control unit and all executors are idle, and keeps
// the issued word stable until the next issue.
module inst_dispatch_queue #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inst_dispatch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RUN, WAIT_DONE, SETTLE} state_e;

  state_e           state_q;
  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      out_q;
  logic             stb_q;
  logic [1:0]       tmo_q;
  logic             full, pop, push, drop;

  // The pop happens while in ISSUE, so a full FIFO can accept a push that cycle.
  assign full = (cnt_q == CNT_W'(DEPTH));
  assign pop  = (state_q == ISSUE);
  assign push = bus.host_write && !bus.flush && (!full || pop);
  assign drop = bus.host_write && !bus.flush && full && !pop;

  // Next-state pointers/count/overflow; flush wins over any push or pop.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (bus.flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
      if (drop) ovf_d = 1'b1;
    end
  end

  // Storage array; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.host_wdata;
  end

  // FIFO bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Issue FSM with registered word/strobe. A flush never aborts an in-flight
  // handshake; it only stops a new issue from starting out of IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      stb_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      stb_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!bus.flush && cnt_q != '0 && !bus.isrunning && !bus.units_busy)
            state_q <= ISSUE;
        end
        ISSUE: begin
          out_q   <= mem_q[rd_q];
          stb_q   <= 1'b1;
          tmo_q   <= '0;
          state_q <= WAIT_RUN;
        end
        WAIT_RUN: begin
          if (bus.isrunning)       state_q <= WAIT_DONE;
          else if (tmo_q == 2'd3)  state_q <= SETTLE;
          else                     tmo_q   <= tmo_q + 2'd1;
        end
        WAIT_DONE: begin
          if (!bus.isrunning) state_q <= SETTLE;
        end
        SETTLE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.host_full     = full;
  assign bus.host_overflow = ovf_q;
  assign bus.fifo_count    = cnt_q;
  assign bus.inst_out      = out_q;
  assign bus.inst_write    = stb_q;
  assign bus.drained       = (cnt_q == '0) && (state_q == IDLE);
endmodule

// File: tb/tb_inst_dispatch_queue.sv
// Randomized bench for inst_dispatch_queue: a queue-based model of the FIFO
// contents, overflow flag and issued word, plus a simple control-unit model.
module tb_inst_dispatch_queue;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_dispatch_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
  inst_dispatch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mq[$];
  bit          m_ovf;
  logic [31:0] m_out;
  int          strobes = 0;
  int          cyc = 0;
  int          last_stb;
  bit          cu_en;
  int          run_left;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf    = 1'b0;
    m_out    = '0;
    run_left = 0;
    last_stb = -100;
  endtask

  // One clock: sample inputs, let the edge happen, update the model, compare,
  // then drive the control-unit model's isrunning for the next cycle.
  task automatic step();
    bit          hw, fl;
    logic [31:0] wd;
    hw = bus.host_write;
    fl = bus.flush;
    wd = bus.host_wdata;
    @(posedge clk); #1;
    cyc++;
    bus.host_write = 1'b0;
    bus.flush      = 1'b0;
    if (bus.inst_write === 1'b1) begin
      chk("stb_nonempty", 32'(mq.size() > 0), 32'd1);
      if (mq.size() > 0) m_out = mq.pop_front();
      chk("stb_gap_ge6", 32'((cyc - last_stb) >= 6), 32'd1);
      last_stb = cyc;
      strobes++;
    end
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (hw) begin
      if (mq.size() < DEPTH) mq.push_back(wd);
      else                   m_ovf = 1'b1;
    end
    chk("inst_out",      bus.inst_out,            m_out);
    chk("fifo_count",    32'(bus.fifo_count),     32'(mq.size()));
    chk("host_full",     32'(bus.host_full),      32'(mq.size() == DEPTH));
    chk("host_overflow", 32'(bus.host_overflow),  32'(m_ovf));
    if (cu_en) begin
      bus.isrunning = (run_left > 0);
      if (run_left > 0) run_left--;
      if (bus.inst_write === 1'b1) run_left = 2;
    end else begin
      bus.isrunning = 1'b0;
    end
  endtask

  task automatic push(logic [31:0] w);
    bus.host_wdata = w;
    bus.host_write = 1'b1;
    step();
  endtask

  task automatic wait_until(int target, int budget, string tag);
    int t = 0;
    while (strobes < target && t < budget) begin
      step();
      t++;
    end
    chk(tag, 32'(strobes >= target), 32'd1);
  endtask

  int base, s1;

  initial begin
    bus.host_wdata = '0;
    bus.host_write = 1'b0;
    bus.flush      = 1'b0;
    bus.isrunning  = 1'b0;
    bus.units_busy = 1'b0;
    cu_en          = 1'b1;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count",   32'(bus.fifo_count),    32'd0);
    chk("rst_full",    32'(bus.host_full),     32'd0);
    chk("rst_ovf",     32'(bus.host_overflow), 32'd0);
    chk("rst_out",     bus.inst_out,           32'd0);
    chk("rst_write",   32'(bus.inst_write),    32'd0);
    chk("rst_drained", 32'(bus.drained),       32'd1);
    rst_n = 1'b1;
    step();

    // 1: single word
    base = strobes;
    push(32'h0000_1234);
    wait_until(base + 1, 20, "t1_strobe");
    chk("t1_inst_out", bus.inst_out, 32'h0000_1234);
    repeat (10) step();
    chk("t1_drained", 32'(bus.drained), 32'd1);

    // 2: three back-to-back words, ordered issue
    base = strobes;
    for (int i = 0; i < 3; i++) push($urandom);
    wait_until(base + 3, 60, "t2_three");
    repeat (10) step();

    // 3: executors busy blocks issue; release issues within 2 cycles
    base = strobes;
    bus.units_busy = 1'b1;
    push($urandom);
    repeat (10) step();
    chk("t3_blocked", 32'(strobes), 32'(base));
    bus.units_busy = 1'b0;
    step();
    step();
    chk("t3_release", 32'(strobes), 32'(base + 1));
    repeat (10) step();

    // 4: overfill by one, then drain in order
    base = strobes;
    bus.units_busy = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) push($urandom);
    chk("t4_count", 32'(bus.fifo_count),    32'(DEPTH));
    chk("t4_full",  32'(bus.host_full),     32'd1);
    chk("t4_ovf",   32'(bus.host_overflow), 32'd1);
    bus.units_busy = 1'b0;
    wait_until(base + DEPTH, 300, "t4_drain");
    repeat (10) step();
    chk("t4_extra", 32'(strobes), 32'(base + DEPTH));
    chk("t4_ovf_sticky", 32'(bus.host_overflow), 32'd1);
    bus.flush = 1'b1;
    step();
    chk("t4_flush_ovf", 32'(bus.host_overflow), 32'd0);

    // 5: push into a full FIFO in the same cycle as the pop
    base = strobes;
    bus.units_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push($urandom);
    bus.units_busy = 1'b0;
    step();
    bus.units_busy = 1'b1;
    push($urandom);
    chk("t5_strobe", 32'(strobes),          32'(base + 1));
    chk("t5_count",  32'(bus.fifo_count),   32'(DEPTH));
    chk("t5_ovf",    32'(bus.host_overflow), 32'd0);
    bus.units_busy = 1'b0;
    wait_until(base + DEPTH + 1, 300, "t5_drain");
    repeat (10) step();
    chk("t5_drained", 32'(bus.drained), 32'd1);

    // 6a: flush during WAIT_DONE with 5 words queued
    base = strobes;
    bus.units_busy = 1'b1;
    for (int i = 0; i < 6; i++) push($urandom);
    bus.units_busy = 1'b0;
    wait_until(base + 1, 20, "t6_first");
    step();
    step();
    chk("t6_queued", 32'(bus.fifo_count), 32'd5);
    bus.flush = 1'b1;
    step();
    repeat (30) step();
    chk("t6_no_more", 32'(strobes),        32'(base + 1));
    chk("t6_count",   32'(bus.fifo_count), 32'd0);
    chk("t6_drained", 32'(bus.drained),    32'd1);

    // 6b: isrunning stuck low, WAIT_RUN times out after 4 cycles
    cu_en = 1'b0;
    base = strobes;
    bus.units_busy = 1'b1;
    push($urandom);
    push($urandom);
    bus.units_busy = 1'b0;
    wait_until(base + 1, 20, "t6_tmo_first");
    s1 = last_stb;
    wait_until(base + 2, 20, "t6_tmo_second");
    chk("t6_tmo_gap", 32'(last_stb - s1), 32'd7);
    repeat (10) step();

    // Async reset in the middle of a handshake
    cu_en = 1'b1;
    base = strobes;
    push(32'hDEAD_BEEF);
    push(32'h0BAD_F00D);
    wait_until(base + 1, 20, "t7_strobe");
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_write",   32'(bus.inst_write), 32'd0);
    chk("t7_rst_out",     bus.inst_out,        32'd0);
    chk("t7_rst_count",   32'(bus.fifo_count), 32'd0);
    chk("t7_rst_drained", 32'(bus.drained),    32'd1);
    model_reset();
    bus.isrunning = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) step();
    chk("t7_idle", 32'(bus.drained), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_dispatch_queue.md
Name: inst_dispatch_queue

Overview:
Buffers 32-bit instructions written by the host over the AvMM IO path and feeds them one at a time to the control unit's instruction input. An instruction is issued only when the control unit is idle and the downstream executors (mover, load-storer, EU) report not busy. The issued word is held stable until the next issue, because the control unit decodes it combinationally two cycles after the write strobe.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
host_wdata  input  32  instruction word from the host
host_write  input  1  host push strobe, one word per cycle
flush  input  1  synchronous queue clear
host_full  output  1  FIFO full
host_overflow  output  1  sticky flag: push attempted while full
fifo_count  output  CNT_W  current occupancy, 0..DEPTH
inst_out  output  32  instruction presented to the control unit (its h2f_io)
inst_write  output  1  one-cycle issue strobe (the control unit's h2f_write)
isrunning  input  1  control unit busy status
units_busy  input  1  OR of mover, load-storer and EU busy signals
drained  output  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset (async, rst_n low): FIFO pointers and count = 0, host_full = 0, host_overflow = 0, inst_out = 0, inst_write = 0, FSM = IDLE, drained = 1.
- FIFO: circular buffer, write/read pointers wrap modulo DEPTH.
  - A push with host_write=1 and not full stores the word and increments count.
  - A push while full drops the word and sets host_overflow, which stays set until reset or flush.
  - A simultaneous push and pop leaves count unchanged. When full, the pop frees the slot in the same cycle, so the push is accepted and host_overflow is not set.
  - host_full = (count == DEPTH). fifo_count is registered.
- FSM states: IDLE, ISSUE, WAIT_RUN, WAIT_DONE, SETTLE.
  - IDLE: if count>0, isrunning=0 and units_busy=0, go to ISSUE.
  - ISSUE: pop the head into inst_out (registered), then go to WAIT_RUN. inst_write is 1 in the cycle after the pop, so inst_out is valid when the strobe is seen.
  - WAIT_RUN: wait for isrunning=1, then go to WAIT_DONE. Timeout: if isrunning has not risen within 4 cycles, go to SETTLE.
  - WAIT_DONE: wait for isrunning=0, then go to SETTLE.
  - SETTLE: one cycle, so that executor busy can assert after the control unit's start pulse; then go to IDLE.
- inst_write is a single-cycle pulse, exactly once per popped instruction. It is never asserted in consecutive cycles.
- inst_out only changes on a pop and holds its value through all other states.
- Minimum issue spacing is 6 cycles, with an ideal control unit (running for 2 cycles) and units_busy=0.
- flush: clears the FIFO pointers, count and host_overflow.
  - In IDLE or SETTLE, the FSM stays or goes to IDLE.
  - In ISSUE, WAIT_RUN or WAIT_DONE, the in-flight instruction completes its handshake, while inst_out and inst_write behave as normal.
  - flush has priority over a same-cycle host_write, so the word is dropped and host_overflow is not set.
- drained = (count==0) and (state==IDLE).
- An async reset mid-handshake returns to the reset state immediately. The control unit is reset on the same rst_n.

Test Plan:
1. Reset, then push 0x0000_1234 with isrunning=0 and units_busy=0 → inst_write pulses once; inst_out=0x0000_1234 in that cycle and afterwards; fifo_count returns to 0; drained=1 after SETTLE.
2. Push 3 words A, B, C back to back, with a model control unit (isrunning high for 2 cycles, 1 cycle after the strobe) → three strobes in order A, B, C, spaced ≥6 cycles apart, with inst_out stable between strobes.
3. Hold units_busy=1 and push one word → no strobe; release units_busy → strobe within 2 cycles.
4. With DEPTH=16 and issue blocked, push 17 words → host_full=1 after 16, host_overflow=1, fifo_count=16; unblock → exactly the first 16 words issue, in order.
5. Full FIFO with issue enabled, and a push in the same cycle as the pop → push accepted, host_overflow stays 0, fifo_count stays 16.
6. flush while in WAIT_DONE with 5 words queued → the in-flight instruction completes; fifo_count=0; no further strobes; drained=1. A separate run with isrunning stuck at 0 → the FSM times out of WAIT_RUN after 4 cycles and issues the next word.
